uart_rx_monitor: RTL and testbench

Parametrised serial-receive monitor for the Caravel DV benches: samples a UART TX pin from the design under test, decodes frames of configurable bit rate, data width, parity and stop bits, and assembles characters into a line buffer that is released on newline. Adds error detection (framing, parity, break), glitch rejection and overflow tracking. Sits in the testbench top, driven by the bench clock, with `ser_rx` tied to the DUT's UART TX pad.

---
 rtl/uart_rx_monitor.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_monitor.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_monitor
// Purpose  : UART receive monitor that decodes serial frames and assembles
//            characters into a line buffer that is released on newline.
//            Optional console output is enabled by UART_RX_MONITOR_DISPLAY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 5,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int LINE_CHARS   = 50
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ser_rx,
  output logic [7:0]                        rx_data,
  output logic                              rx_valid,
  output logic                              frame_err,
  output logic                              parity_err,
  output logic [8*LINE_CHARS-1:0]           line_buf,
  output logic [$clog2(LINE_CHARS+1)-1:0]   line_len,
  output logic                              line_done,
  output logic                              line_ovf
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int IW  = $clog2(DATA_BITS + 1);
  localparam int LW  = $clog2(LINE_CHARS + 1);
  localparam int LBW = 8 * LINE_CHARS;

  localparam logic [CW-1:0] CNT_HALF      = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL      = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [LW-1:0] LEN_MAX       = LW'(LINE_CHARS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t                 state;
  logic                   sync1;
  logic                   rx_s;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bad;
  logic                   stop_bad;
  logic [7:0]             char_ext;
  logic                   bit_hit;
  logic                   frame_bad;

  always_comb begin
    char_ext                  = '0;
    char_ext[DATA_BITS-1:0]   = shreg;
    bit_hit                   = (cnt == CNT_FULL);
    frame_bad                 = stop_bad | ~rx_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sync1      <= 1'b1;
      rx_s       <= 1'b1;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      line_buf   <= '0;
      line_len   <= '0;
      line_done  <= 1'b0;
      line_ovf   <= 1'b0;
    end else begin
      sync1     <= ser_rx;
      rx_s      <= sync1;
      rx_valid  <= 1'b0;
      line_done <= 1'b0;

      // The completed line stays visible for the line_done cycle only.
      if (line_done) begin
        line_buf <= '0;
        line_len <= '0;
        line_ovf <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= S_START;
        end

        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt      <= '0;
            idx      <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            state    <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (bit_hit) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (idx == IDX_DATA_LAST) begin
              idx   <= '0;
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_PARITY: begin
          if (bit_hit) begin
            cnt     <= '0;
            par_bad <= ((^shreg) ^ rx_s) != (PARITY == 1);
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (bit_hit) begin
            cnt <= '0;
            if (idx == IDX_STOP_LAST) begin
              idx        <= '0;
              rx_valid   <= 1'b1;
              rx_data    <= char_ext;
              frame_err  <= frame_bad;
              parity_err <= par_bad;
              if (!frame_bad && !par_bad) begin
                if (char_ext == 8'h0a) begin
                  line_done <= 1'b1;
                end else begin
                  line_buf <= (line_buf << 8) | LBW'(char_ext);
                  if (line_len == LEN_MAX) line_ovf <= 1'b1;
                  else                     line_len <= line_len + LW'(1);
                end
              end
              // A low final stop sample means the line is held low: wait it out.
              state <= rx_s ? S_IDLE : S_BREAK;
            end else begin
              idx      <= idx + IW'(1);
              stop_bad <= frame_bad;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_BREAK: begin
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_RX_MONITOR_DISPLAY_EN
  always @(posedge clk) begin
    if (line_done) $display("output: %s", line_buf);
    if (rx_valid && (frame_err || parity_err))
      $display("uart_rx_monitor warning: bad char 0x%02h frame_err=%0b parity_err=%0b at %0t",
               rx_data, frame_err, parity_err, $time);
  end
`else
  // Console output disabled.
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_monitor
// Purpose  : Bench for uart_rx_monitor; three instances (default, even parity,
//            4-character line) checked against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_monitor;

  localparam int CPB  = 5;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rxl = 3'b111;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]       rv, fe, pe, ld, lo;
  logic [2:0][7:0]  rd;
  logic [399:0]     lb0, lb1;
  logic [31:0]      lb2;
  logic [5:0]       ll0, ll1;
  logic [2:0]       ll2;

  uart_rx_monitor #(.CLKS_PER_BIT(CPB)) d0 (
    .clk(clk), .rst(rst), .ser_rx(rxl[0]), .rx_data(rd[0]), .rx_valid(rv[0]),
    .frame_err(fe[0]), .parity_err(pe[0]), .line_buf(lb0), .line_len(ll0),
    .line_done(ld[0]), .line_ovf(lo[0]));

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .PARITY(2)) d1 (
    .clk(clk), .rst(rst), .ser_rx(rxl[1]), .rx_data(rd[1]), .rx_valid(rv[1]),
    .frame_err(fe[1]), .parity_err(pe[1]), .line_buf(lb1), .line_len(ll1),
    .line_done(ld[1]), .line_ovf(lo[1]));

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .LINE_CHARS(4)) d2 (
    .clk(clk), .rst(rst), .ser_rx(rxl[2]), .rx_data(rd[2]), .rx_valid(rv[2]),
    .frame_err(fe[2]), .parity_err(pe[2]), .line_buf(lb2), .line_len(ll2),
    .line_done(ld[2]), .line_ovf(lo[2]));

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         cyc;
  } exp_t;

  exp_t         eq [3][64];
  int           eh [3];
  int           et [3];
  logic [7:0]   mline [3][50];
  int           mlen [3];
  logic         movf [3];
  logic         clr_pend [3];
  logic         snap_pend [3];
  int           snap_len [3];
  int           snap_nlen [3];
  logic         snap_novf [3];
  logic [399:0] snap_buf [3];
  int           total = 0;
  int           bad = 0;

  function automatic int cap(input int i);
    return (i == 2) ? 4 : 50;
  endfunction

  function automatic logic [399:0] pack_line(input int i);
    logic [399:0] r;
    r = '0;
    for (int k = 0; k < mlen[i]; k++) r = (r << 8) | {392'b0, mline[i][k]};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [399:0] act, input logic [399:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame-level reference: one expected frame per rx_valid, line kept as a char array.
  task automatic mon_inst(input int i, input logic v, input logic [7:0] d, input logic f,
                          input logic p, input logic [399:0] lb, input int ll,
                          input logic done, input logic ov);
    exp_t e;
    logic exp_done;
    if (clr_pend[i]) begin
      mlen[i] = 0;
      movf[i] = 1'b0;
      clr_pend[i] = 1'b0;
    end
    if (snap_pend[i]) begin
      snap_nlen[i] = ll;
      snap_novf[i] = ov;
      snap_pend[i] = 1'b0;
    end
    exp_done = 1'b0;
    if (!v && eh[i] != et[i] && cyc > eq[i][eh[i]].cyc) begin
      total++;
      bad++;
      $display("FAIL d%0d missed rx_valid: got none expected at cyc %0d", i, eq[i][eh[i]].cyc);
      eh[i]++;
    end
    if (v) begin
      if (eh[i] == et[i]) begin
        total++;
        bad++;
        $display("FAIL d%0d unexpected rx_valid: got 1 expected 0 at cyc %0d", i, cyc);
      end else begin
        e = eq[i][eh[i]];
        eh[i]++;
        chk($sformatf("d%0d rx_valid cycle", i), 400'(cyc), 400'(e.cyc));
        chk($sformatf("d%0d rx_data", i), 400'(d), 400'(e.d));
        chk($sformatf("d%0d frame_err", i), 400'(f), 400'(e.fe));
        chk($sformatf("d%0d parity_err", i), 400'(p), 400'(e.pe));
        if (!e.fe && !e.pe) begin
          if (e.d == 8'h0a) begin
            exp_done = 1'b1;
            clr_pend[i] = 1'b1;
          end else if (mlen[i] == cap(i)) begin
            for (int k = 0; k < cap(i) - 1; k++) mline[i][k] = mline[i][k+1];
            mline[i][cap(i)-1] = e.d;
            movf[i] = 1'b1;
          end else begin
            mline[i][mlen[i]] = e.d;
            mlen[i]++;
          end
        end
      end
    end
    chk($sformatf("d%0d line_done", i), 400'(done), 400'(exp_done));
    chk($sformatf("d%0d line_len", i), 400'(ll), 400'(mlen[i]));
    chk($sformatf("d%0d line_ovf", i), 400'(ov), 400'(movf[i]));
    chk($sformatf("d%0d line_buf", i), lb, pack_line(i));
    if (done) begin
      snap_len[i]  = ll;
      snap_buf[i]  = lb;
      snap_pend[i] = 1'b1;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 3; i++) begin
          mlen[i] = 0;
          movf[i] = 1'b0;
          clr_pend[i] = 1'b0;
          snap_pend[i] = 1'b0;
        end
      end else begin
        mon_inst(0, rv[0], rd[0], fe[0], pe[0], lb0, int'(ll0), ld[0], lo[0]);
        mon_inst(1, rv[1], rd[1], fe[1], pe[1], lb1, int'(ll1), ld[1], lo[1]);
        mon_inst(2, rv[2], rd[2], fe[2], pe[2], {368'b0, lb2}, int'(ll2), ld[2], lo[2]);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int i, input logic b);
    rxl[i] = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic push_exp(input int i, input logic [7:0] d, input logic f, input logic p,
                          input int nbits);
    eq[i][et[i]].d   = d;
    eq[i][et[i]].fe  = f;
    eq[i][et[i]].pe  = p;
    // First edge seeing the pin, 2 sync flops, half-bit start sample, then whole bits.
    eq[i][et[i]].cyc = cyc + 1 + 2 + HALF + CPB * nbits;
    et[i]++;
  endtask

  task automatic send(input int i, input logic [7:0] ch, input logic badp);
    int p;
    p = (i == 1) ? 1 : 0;
    push_exp(i, ch, 1'b0, (p == 1) ? badp : 1'b0, 8 + p + 1);
    drive_bit(i, 1'b0);
    for (int b = 0; b < 8; b++) drive_bit(i, ch[b]);
    if (p == 1) drive_bit(i, (^ch) ^ badp);
    drive_bit(i, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      eh[i] = 0; et[i] = 0; mlen[i] = 0; movf[i] = 1'b0; clr_pend[i] = 1'b0;
      snap_pend[i] = 1'b0; snap_len[i] = -1; snap_nlen[i] = -1; snap_novf[i] = 1'b1;
      snap_buf[i] = '1;
    end
    fork
      monitor();
    join_none

    idle(3);
    chk("reset rx_data", 400'(rd[0]), 400'h0);
    chk("reset rx_valid", 400'(rv[0]), 400'h0);
    chk("reset frame_err", 400'(fe[0]), 400'h0);
    chk("reset parity_err", 400'(pe[0]), 400'h0);
    chk("reset line_buf", lb0, 400'h0);
    chk("reset line_len", 400'(ll0), 400'h0);
    chk("reset line_done", 400'(ld[0]), 400'h0);
    chk("reset line_ovf", 400'(lo[0]), 400'h0);
    rst = 1'b0;
    idle(5);

    // "Hi\n" back to back
    send(0, 8'h48, 1'b0);
    send(0, 8'h69, 1'b0);
    send(0, 8'h0a, 1'b0);
    idle(10);
    chk("Hi line_len at line_done", 400'(snap_len[0]), 400'd2);
    chk("Hi line_buf at line_done", 400'(snap_buf[0][15:0]), 400'h4869);
    chk("Hi line_len after line_done", 400'(snap_nlen[0]), 400'd0);

    // Two-cycle glitch, then a clean 'A'
    rxl[0] = 1'b0;
    idle(2);
    rxl[0] = 1'b1;
    idle(10);
    send(0, 8'h41, 1'b0);
    idle(5);

    // Line held low for 30 bit times
    push_exp(0, 8'h00, 1'b1, 1'b0, 9);
    rxl[0] = 1'b0;
    idle(30 * CPB);
    rxl[0] = 1'b1;
    idle(10);
    send(0, 8'h31, 1'b0);
    idle(5);
    chk("after break line_len", 400'(ll0), 400'd2);
    chk("after break line_buf", 400'(lb0[15:0]), 400'h4131);

    // Even parity instance
    send(1, 8'h55, 1'b1);
    idle(5);
    chk("bad parity line_len", 400'(ll1), 400'd0);
    send(1, 8'h55, 1'b0);
    idle(5);
    chk("good parity line_len", 400'(ll1), 400'd1);
    chk("good parity line_buf", 400'(lb1[7:0]), 400'h55);

    // 4-character line overflow
    send(2, 8'h41, 1'b0);
    send(2, 8'h42, 1'b0);
    send(2, 8'h43, 1'b0);
    send(2, 8'h44, 1'b0);
    idle(3);
    chk("ovf after D", 400'(lo[2]), 400'h0);
    send(2, 8'h45, 1'b0);
    idle(3);
    chk("ovf after E", 400'(lo[2]), 400'h1);
    send(2, 8'h46, 1'b0);
    send(2, 8'h0a, 1'b0);
    idle(10);
    chk("ovf line_len at line_done", 400'(snap_len[2]), 400'd4);
    chk("ovf line_buf at line_done", 400'(snap_buf[2][31:0]), 400'h43444546);
    chk("ovf cleared after line_done", 400'(snap_novf[2]), 400'h0);

    // Reset during the data bits of 0x7E
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    rst = 1'b1;
    rxl[0] = 1'b1;
    @(negedge clk);
    chk("mid reset rx_data", 400'(rd[0]), 400'h0);
    chk("mid reset rx_valid", 400'(rv[0]), 400'h0);
    chk("mid reset line_buf", lb0, 400'h0);
    chk("mid reset line_len", 400'(ll0), 400'h0);
    idle(2);
    rst = 1'b0;
    idle(10);
    send(0, 8'h7e, 1'b0);
    idle(5);
    chk("after reset rx_data", 400'(rd[0]), 400'h7e);
    chk("after reset line_buf", 400'(lb0[7:0]), 400'h7e);

    idle(20);
    for (int i = 0; i < 3; i++)
      chk($sformatf("d%0d frames outstanding", i), 400'(et[i] - eh[i]), 400'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
